// File: rtl/evenodd_seq_ctrl.sv
// evenodd_seq_ctrl: emits even and/or odd values up to MAXV in a selectable
// order over a valid/ready handshake, for a fixed count or continuously.
module evenodd_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int MAXV  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic [1:0]       mode,
  input  logic [3:0]       len,
  input  logic             q_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Order encodings of the mode input.
  localparam logic [1:0] MODE_EVEN_ODD = 2'b00;
  localparam logic [1:0] MODE_ODD_EVEN = 2'b01;
  localparam logic [1:0] MODE_EVEN     = 2'b10;
  localparam logic [1:0] MODE_ODD      = 2'b11;

  localparam logic [WIDTH-1:0] MAX_EVEN = WIDTH'(MAXV);
  localparam logic [WIDTH-1:0] MAX_ODD  = WIDTH'(MAXV - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       mode_r;      // order captured at start
  logic [3:0]       len_r;       // run length captured at start, 0 = endless
  logic [3:0]       cnt;         // values accepted so far in this run
  logic [3:0]       cnt_inc;
  logic             launch;      // start accepted this cycle
  logic             accept;      // handshake completes this cycle
  logic             last;        // this accept would complete a bounded run
  logic [WIDTH-1:0] q_first;
  logic [WIDTH-1:0] q_next;

  // First value of a run: odd-first orders begin at 1, even-first at 2.
  assign q_first = mode[0] ? ONE : TWO;

  // The run ends on the accept that brings the count up to a nonzero length.
  assign cnt_inc = cnt + 4'd1;
  assign last    = (len_r != 4'd0) && (cnt_inc == len_r);

  // Successor of q within the latched order, including the phase wraps.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    q_next = q + TWO;
    unique case (mode_r)
      MODE_EVEN_ODD,
      MODE_ODD_EVEN: begin
        // Both mixed orders swap phase at the top of each phase; they differ
        // only in which phase they start with.
        if (q == MAX_EVEN)     q_next = ONE;
        else if (q == MAX_ODD) q_next = TWO;
      end
      MODE_EVEN: if (q == MAX_EVEN) q_next = TWO;
      MODE_ODD:  if (q == MAX_ODD)  q_next = ONE;
      default:   q_next = q + TWO;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs; stop outranks hold, hold outranks accept.
  always_comb begin
    state_nxt = state;
    q_valid   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    launch    = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          launch    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        q_valid = !hold && !stop;
        accept  = q_valid && q_ready;
        if (stop)                state_nxt = IDLE;
        else if (accept && last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture run settings on start, advance q and count on accept.
  // The final accept of a bounded run leaves q on the last accepted value,
  // and q keeps its value through DONE and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= '0;
      cnt    <= 4'd0;
      mode_r <= 2'b00;
      len_r  <= 4'd0;
    end else if (launch) begin
      q      <= q_first;
      cnt    <= 4'd0;
      mode_r <= mode;
      len_r  <= len;
    end else if (accept) begin
      cnt <= cnt_inc;
      if (!last) q <= q_next;
    end
  end

endmodule

// File: tb/tb_evenodd_seq_ctrl.sv
// Directed bench for evenodd_seq_ctrl (WIDTH=4, MAXV=8), hand-derived vectors.
module tb_evenodd_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, hold, q_ready;
  logic [1:0] mode;
  logic [3:0] len;
  logic [3:0] q;
  logic       q_valid, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  evenodd_seq_ctrl #(.WIDTH(4), .MAXV(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .hold    (hold),
    .mode    (mode),
    .len     (len),
    .q_ready (q_ready),
    .q       (q),
    .q_valid (q_valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Move 1 time unit past the next rising edge; inputs are changed there and
  // outputs are sampled 1 unit later, both well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge; q then shows the first value of the run.
  task automatic launch(input logic [1:0] m, input logic [3:0] l);
    start = 1'b1; mode = m; len = l;
    tick();
    start = 1'b0;
  endtask

  logic [3:0] exp_q [];

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; q_ready = 1'b0;
    mode = 2'b00; len = 4'd0;
    #12;
    check("rst_q", q, 0);
    check("rst_valid", q_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // Mode 00, len 8, ready always high.
    q_ready = 1'b1;
    launch(2'b00, 4'd8);
    exp_q = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7};
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("m00_valid%0d", i), q_valid, 1);
      check($sformatf("m00_q%0d", i), q, exp_q[i]);
      check($sformatf("m00_done%0d", i), done, 0);
      tick();
    end
    #1;
    check("m00_done", done, 1);
    check("m00_done_valid", q_valid, 0);
    check("m00_done_busy", busy, 1);
    check("m00_done_q", q, 7);
    tick(); #1;
    check("m00_idle_busy", busy, 0);
    check("m00_idle_done", done, 0);
    check("m00_idle_q", q, 7);

    // Mode 01, continuous, then stop.
    tick();
    launch(2'b01, 4'd0);
    exp_q = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd2, 4'd4, 4'd6, 4'd8, 4'd1, 4'd3};
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("m01_q%0d", i), q, exp_q[i]);
      check($sformatf("m01_done%0d", i), done, 0);
      tick();
    end
    stop = 1'b1;
    #1;
    check("m01_stop_valid", q_valid, 0);
    check("m01_stop_q", q, 5);
    tick();
    stop = 1'b0;
    #1;
    check("m01_after_busy", busy, 0);
    check("m01_after_valid", q_valid, 0);
    check("m01_after_done", done, 0);
    check("m01_after_q", q, 5);

    // Mode 10, len 5, ready alternating 1,0.
    tick();
    launch(2'b10, 4'd5);
    exp_q = '{4'd2, 4'd4, 4'd4, 4'd6, 4'd6, 4'd8, 4'd8, 4'd2, 4'd2};
    for (int i = 0; i < 9; i++) begin
      q_ready = (i % 2 == 0);
      #1;
      check($sformatf("m10_q%0d", i), q, exp_q[i]);
      check($sformatf("m10_valid%0d", i), q_valid, 1);
      check($sformatf("m10_done%0d", i), done, 0);
      tick();
    end
    q_ready = 1'b1;
    #1;
    check("m10_done", done, 1);
    check("m10_done_q", q, 2);
    tick(); #1;
    check("m10_idle_busy", busy, 0);

    // Mode 11, len 3, hold for 4 cycles after the first accept.
    tick();
    launch(2'b11, 4'd3);
    #1;
    check("m11_q0", q, 1);
    check("m11_valid0", q_valid, 1);
    tick();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("m11_hold_q%0d", i), q, 3);
      check($sformatf("m11_hold_valid%0d", i), q_valid, 0);
      check($sformatf("m11_hold_busy%0d", i), busy, 1);
      tick();
    end
    hold = 1'b0;
    #1;
    check("m11_q1", q, 3);
    check("m11_valid1", q_valid, 1);
    tick(); #1;
    check("m11_q2", q, 5);
    check("m11_done_early", done, 0);
    tick(); #1;
    check("m11_done", done, 1);
    check("m11_done_q", q, 5);
    tick();

    // Asynchronous reset mid-run while q is 6.
    launch(2'b00, 4'd0);
    tick(); tick(); #1;
    check("rstmid_pre_q", q, 6);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_q", q, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_valid", q_valid, 0);
    check("rstmid_done", done, 0);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check($sformatf("rstmid_wait_busy%0d", i), busy, 0);
      check($sformatf("rstmid_wait_done%0d", i), done, 0);
    end

    // start with stop in IDLE is ignored.
    start = 1'b1; stop = 1'b1; mode = 2'b10; len = 4'd0;
    tick(); #1;
    check("startstop_busy", busy, 0);
    check("startstop_q", q, 0);
    // start held high through RUN must not restart; mode change has no effect.
    stop = 1'b0;
    tick();
    mode = 2'b11;
    exp_q = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd2};
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("hold_start_q%0d", i), q, exp_q[i]);
      check($sformatf("hold_start_busy%0d", i), busy, 1);
      tick();
    end
    start = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    #1;
    check("final_busy", busy, 0);
    check("final_done", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
